byte_lane_dly_loader: RTL and testbench



---
 rtl/byte_lane_dly_loader_pkg.sv | 40 ++++
 rtl/byte_lane_dly_loader_dly_table.sv | 70 +++++++
 rtl/byte_lane_dly_loader.sv | 126 ++++++++++++
 tb/tb_byte_lane_dly_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_dly_loader_pkg.sv
// Shared constants, FSM encoding and address helpers for the byte-lane delay loader.
// Table addresses: bit 4 selects input delays; low nibble is DQ0-7, DQS (8), DM (9, output only).
package byte_lane_dly_loader_pkg;

  localparam int DLY_ADDR_DQS = 8;
  localparam int DLY_ADDR_DM  = 9;
  localparam int DLY_IN_BIT   = 4;
  localparam int DLY_NUM_OUT  = 10;
  localparam int DLY_NUM_IN   = 9;
  localparam int DLY_NUM      = DLY_NUM_OUT + DLY_NUM_IN;

  localparam logic [4:0] DLY_ADDR_OUT_FIRST = 5'd0;
  localparam logic [4:0] DLY_ADDR_OUT_LAST  = 5'(DLY_ADDR_DM);
  localparam logic [4:0] DLY_ADDR_IN_FIRST  = 5'(1 << DLY_IN_BIT);
  localparam logic [4:0] DLY_ADDR_IN_LAST   = 5'((1 << DLY_IN_BIT) + DLY_ADDR_DQS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_SET,
    ST_DONE
  } state_e;

  function automatic logic dly_addr_valid(input logic [4:0] a);
    logic ok;
    if (a[DLY_IN_BIT]) ok = (a[3:0] < 4'(DLY_NUM_IN));
    else               ok = (a[3:0] < 4'(DLY_NUM_OUT));
    return ok;
  endfunction

  // Packs the sparse address space into a dense 0..18 index (outputs first).
  function automatic logic [4:0] dly_addr_idx(input logic [4:0] a);
    logic [4:0] idx;
    if (a[DLY_IN_BIT]) idx = 5'(DLY_NUM_OUT) + {1'b0, a[3:0]};
    else               idx = {1'b0, a[3:0]};
    return idx;
  endfunction

endpackage

// File: rtl/byte_lane_dly_loader_dly_table.sv
// 19-entry shadow table of lane delays: one write port, a registered sequencer read port
// and a registered readback port. Invalid addresses are dropped on write and read as zero.
module dly_table
  import byte_lane_dly_loader_pkg::*;
#(
  parameter logic [7:0] DLY_DEFAULT = 8'h00
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       seq_en,
  input  logic [4:0] seq_addr,
  output logic [7:0] seq_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [DLY_NUM];
  logic [7:0] seq_data_q;
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  logic       wr_ok;
  logic       seq_ok;
  logic       rd_ok;
  logic [4:0] wr_idx;
  logic [4:0] seq_idx;
  logic [4:0] rd_idx;

  assign wr_ok   = wr_en && dly_addr_valid(wr_addr);
  assign seq_ok  = dly_addr_valid(seq_addr);
  assign rd_ok   = dly_addr_valid(rd_addr);
  assign wr_idx  = dly_addr_idx(wr_addr);
  assign seq_idx = dly_addr_idx(seq_addr);
  assign rd_idx  = dly_addr_idx(rd_addr);

  // Readback forwards a same-cycle write; the sequencer port deliberately does not,
  // so an entry being issued goes out with the value it held when it was selected.
  always_comb begin
    rd_data_d = 8'h00;
    if (rd_ok) begin
      if (wr_ok && (wr_idx == rd_idx)) rd_data_d = wr_data;
      else                             rd_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY_NUM; i++) mem_q[i] <= DLY_DEFAULT;
    end else if (wr_ok) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      seq_data_q <= 8'h00;
      rd_data_q  <= 8'h00;
    end else begin
      if (seq_en) seq_data_q <= seq_ok ? mem_q[seq_idx] : 8'h00;
      rd_data_q <= rd_data_d;
    end
  end

  assign seq_data = seq_data_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/byte_lane_dly_loader.sv
// Streams the lane delay table into one DDR3 byte lane as ld_delay strobes, then one set.
// Outputs are registered from the next-state decode so the first load follows start by one cycle.
module byte_lane_dly_loader
  import byte_lane_dly_loader_pkg::*;
#(
  parameter logic [7:0] DLY_DEFAULT = 8'h00,
  parameter int         SET_GAP     = 0
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       start,
  input  logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] dly_data,
  output logic [4:0] dly_addr,
  output logic       ld_delay,
  output logic       set
);

  localparam logic [1:0] GAP_LAST = (SET_GAP > 0) ? 2'(SET_GAP - 1) : 2'd0;

  state_e     state_q, state_d;
  logic       in_q, in_d;
  logic [4:0] ent_q, ent_d;
  logic [1:0] gap_q, gap_d;
  logic       ld_q, ld_d;
  logic       set_q, set_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       last_ent;

  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    ent_d    = ent_q;
    gap_d    = gap_q;
    // Output block ends at DM unless input delays follow; input block always ends at DQS.
    last_ent = (ent_q == DLY_ADDR_IN_LAST) || ((ent_q == DLY_ADDR_OUT_LAST) && !in_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          in_d = sel[1];
          if (sel != 2'b00) begin
            state_d = ST_LOAD;
            ent_d   = sel[0] ? DLY_ADDR_OUT_FIRST : DLY_ADDR_IN_FIRST;
          end else begin
            state_d = ST_SET;
          end
        end
      end
      ST_LOAD: begin
        if (last_ent) begin
          state_d = (SET_GAP > 0) ? ST_GAP : ST_SET;
          gap_d   = GAP_LAST;
        end else if (ent_q == DLY_ADDR_OUT_LAST) begin
          ent_d = DLY_ADDR_IN_FIRST;
        end else begin
          ent_d = ent_q + 5'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == 2'd0) state_d = ST_SET;
        else               gap_d   = gap_q - 2'd1;
      end
      ST_SET:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    ld_d   = (state_d == ST_LOAD);
    set_d  = (state_d == ST_SET);
    done_d = (state_d == ST_DONE);
    busy_d = ld_d || set_d || (state_d == ST_GAP);
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in_q    <= 1'b0;
      ent_q   <= 5'd0;
      gap_q   <= 2'd0;
      ld_q    <= 1'b0;
      set_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      ent_q   <= ent_d;
      gap_q   <= gap_d;
      ld_q    <= ld_d;
      set_q   <= set_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  dly_table #(
    .DLY_DEFAULT(DLY_DEFAULT)
  ) u_table (
    .clk_div (clk_div),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .seq_en  (ld_d),
    .seq_addr(ent_d),
    .seq_data(dly_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign dly_addr = ent_q;
  assign ld_delay = ld_q;
  assign set      = set_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_byte_lane_dly_loader.sv
// Directed bench for byte_lane_dly_loader: two instances (SET_GAP 0 and 2) sharing the table
// write/read stimulus, with sequence outputs captured per cycle and compared to hand values.
module tb_byte_lane_dly_loader;

  logic       clk_div = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] rd_addr;
  logic       start_a, start_b;
  logic [1:0] sel;

  logic [7:0] rd_data_a, rd_data_b, dly_data_a, dly_data_b;
  logic [4:0] dly_addr_a, dly_addr_b;
  logic       busy_a, busy_b, done_a, done_b, ld_a, ld_b, set_a, set_b;

  int total = 0;
  int bad   = 0;

  logic [4:0] cap_addr [64];
  logic [7:0] cap_data [64];
  int         cap_cyc  [64];
  int ld_n, set_n, set_cyc, done_n, done_cyc, busy_n;

  always #5 clk_div = ~clk_div;

  byte_lane_dly_loader #(.DLY_DEFAULT(8'h15), .SET_GAP(0)) dut_a (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .start(start_a), .sel(sel), .busy(busy_a),
    .done(done_a), .dly_data(dly_data_a), .dly_addr(dly_addr_a), .ld_delay(ld_a), .set(set_a)
  );

  byte_lane_dly_loader #(.DLY_DEFAULT(8'h15), .SET_GAP(2)) dut_b (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .start(start_b), .sel(sel), .busy(busy_b),
    .done(done_b), .dly_data(dly_data_b), .dly_addr(dly_addr_b), .ld_delay(ld_b), .set(set_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk_div); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(posedge clk_div); #1;
    chk(tag, rd_data_a, exp);
  endtask

  // Called one step after a rising edge; that next edge is cycle 0 (start sampled).
  task automatic run_seq(input logic [1:0] s, input bit use_b,
                         input int rs_cyc, input int wc1, input logic [4:0] wa1,
                         input logic [7:0] wd1, input int wc2, input logic [4:0] wa2,
                         input logic [7:0] wd2);
    logic o_ld, o_set, o_done, o_busy;
    ld_n = 0; set_n = 0; set_cyc = 0; done_n = 0; done_cyc = 0; busy_n = 0;
    sel = s;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk_div); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_div);
      o_ld   = use_b ? ld_b   : ld_a;
      o_set  = use_b ? set_b  : set_a;
      o_done = use_b ? done_b : done_a;
      o_busy = use_b ? busy_b : busy_a;
      if (o_ld) begin
        cap_addr[ld_n] = use_b ? dly_addr_b : dly_addr_a;
        cap_data[ld_n] = use_b ? dly_data_b : dly_data_a;
        cap_cyc[ld_n]  = k;
        ld_n++;
      end
      if (o_set) begin set_n++; if (set_cyc == 0) set_cyc = k; end
      if (o_done) begin done_n++; if (done_cyc == 0) done_cyc = k; end
      if (o_busy) busy_n++;
      if (k == rs_cyc) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (k == wc1) begin wr_addr = wa1; wr_data = wd1; wr_en = 1'b1; end
      if (k == wc2) begin wr_addr = wa2; wr_data = wd2; wr_en = 1'b1; end
      @(posedge clk_div); #1;
      start_a = 1'b0; start_b = 1'b0; wr_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start_a = 1'b0; start_b = 1'b0; sel = 2'b00;
    repeat (2) @(posedge clk_div);
    #1;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ld", ld_a, 1'b0);
    chk("rst_set", set_a, 1'b0);
    chk("rst_dly_addr", dly_addr_a, 5'd0);
    chk("rst_dly_data", dly_data_a, 8'h00);
    chk("rst_rd_data", rd_data_a, 8'h00);
    rst = 1'b0;
    @(posedge clk_div); #1;
    rd("rd_default5", 5'd5, 8'h15);

    // Full table at defaults, no gap.
    run_seq(2'b11, 1'b0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("full_ld_n", ld_n, 19);
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("full_addr%0d", i), cap_addr[i], (i < 10) ? i : 16 + i - 10);
      chk($sformatf("full_data%0d", i), cap_data[i], 8'h15);
    end
    chk("full_first_cyc", cap_cyc[0], 1);
    chk("full_set_cyc", set_cyc, 20);
    chk("full_set_n", set_n, 1);
    chk("full_done_cyc", done_cyc, 21);
    chk("full_busy_n", busy_n, 20);

    // Same on the SET_GAP=2 instance.
    run_seq(2'b11, 1'b1, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("gap_ld_n", ld_n, 19);
    chk("gap_last_addr", cap_addr[18], 5'd24);
    chk("gap_set_cyc", set_cyc, 22);
    chk("gap_done_cyc", done_cyc, 23);
    chk("gap_busy_n", busy_n, 22);

    // Program distinct values and stream the output block only.
    for (int n = 0; n < 10; n++) wr(5'(n), 8'(8'h20 + n));
    for (int n = 0; n < 9; n++)  wr(5'(16 + n), 8'(8'h40 + n));
    run_seq(2'b01, 1'b0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("out_ld_n", ld_n, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("out_addr%0d", i), cap_addr[i], i);
      chk($sformatf("out_data%0d", i), cap_data[i], 8'h20 + i);
    end
    chk("out_set_cyc", set_cyc, 11);
    chk("out_done_cyc", done_cyc, 12);
    chk("hold_dly_addr", dly_addr_a, 5'd9);
    chk("hold_dly_data", dly_data_a, 8'h29);

    // Invalid addresses are dropped on write and read as zero.
    wr(5'd10, 8'hAA);
    wr(5'd25, 8'hBB);
    wr(5'd31, 8'hCC);
    rd("rd_inv10", 5'd10, 8'h00);
    rd("rd_inv25", 5'd25, 8'h00);
    rd("rd_inv15", 5'd15, 8'h00);
    rd("rd_dm", 5'd9, 8'h29);
    rd("rd_in0", 5'd16, 8'h40);
    rd("rd_in_dqs", 5'd24, 8'h48);
    run_seq(2'b10, 1'b0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("in_ld_n", ld_n, 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("in_addr%0d", i), cap_addr[i], 16 + i);
      chk($sformatf("in_data%0d", i), cap_data[i], 8'h40 + i);
    end
    chk("in_set_cyc", set_cyc, 10);

    // Writes during LOAD: entry 3 written as it is issued, entry 7 written well before.
    run_seq(2'b01, 1'b0, 0, 4, 5'd3, 8'hE3, 2, 5'd7, 8'hE7);
    chk("wl_ld_n", ld_n, 10);
    chk("wl_cyc3", cap_cyc[3], 4);
    chk("wl_data3_old", cap_data[3], 8'h23);
    chk("wl_data7_new", cap_data[7], 8'hE7);
    chk("wl_data6", cap_data[6], 8'h26);
    rd("rd_after_wl3", 5'd3, 8'hE3);

    // start while busy is ignored.
    run_seq(2'b11, 1'b0, 5, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("busy_start_ld_n", ld_n, 19);
    chk("busy_start_set_n", set_n, 1);
    chk("busy_start_done_cyc", done_cyc, 21);

    // sel = 0: set only.
    run_seq(2'b00, 1'b0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("sel0_ld_n", ld_n, 0);
    chk("sel0_set_cyc", set_cyc, 1);
    chk("sel0_done_cyc", done_cyc, 2);
    chk("sel0_busy_n", busy_n, 1);

    // Back-to-back: start accepted in the DONE cycle.
    run_seq(2'b10, 1'b0, 11, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("b2b_ld_n", ld_n, 18);
    chk("b2b_done_cyc", done_cyc, 11);
    chk("b2b_second_cyc", cap_cyc[9], 12);
    chk("b2b_second_addr", cap_addr[9], 5'd16);
    chk("b2b_set_n", set_n, 2);
    chk("b2b_done_n", done_n, 2);

    // Reset in the middle of LOAD aborts without set/done and restores defaults.
    sel = 2'b11; start_a = 1'b1;
    @(posedge clk_div); #1;
    start_a = 1'b0;
    repeat (5) @(negedge clk_div);
    chk("mid_ld_before", ld_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_ld", ld_a, 1'b0);
    chk("mid_busy", busy_a, 1'b0);
    chk("mid_set", set_a, 1'b0);
    chk("mid_dly_addr", dly_addr_a, 5'd0);
    @(posedge clk_div); #1;
    rst = 1'b0;
    set_n = 0; done_n = 0; ld_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_div);
      if (set_a) set_n++;
      if (done_a) done_n++;
      if (ld_a) ld_n++;
    end
    chk("abort_set_n", set_n, 0);
    chk("abort_done_n", done_n, 0);
    chk("abort_ld_n", ld_n, 0);
    @(posedge clk_div); #1;
    rd("abort_rd0", 5'd0, 8'h15);
    rd("abort_rd3", 5'd3, 8'h15);
    rd("abort_rd24", 5'd24, 8'h15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
